// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Sequences a width-bit up-counter through one-shot or auto-reload runs
//   toward a host-programmed terminal value. Supports pause (hold), stop
//   (abort to IDLE) and restart, and keeps a tally of completed periods.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      begin/restart; limit and mode sampled on this edge
//   stop     in   1      abort sequence, return to IDLE
//   pause    in   1      level; counter holds while high (RUN/HOLD only)
//   mode     in   1      0 = one-shot, 1 = auto-reload
//   limit    in   width  terminal count value (0 rejects the start)
//   count    out  width  current counter value
//   busy     out  1      state is RUN or HOLD
//   paused   out  1      state is HOLD
//   done     out  1      one-cycle pulse at each terminal count
//   err      out  1      one-cycle pulse when a start is rejected
//   periods  out  8      done pulses since last accepted start (wraps)
module counter_sequencer #(
    parameter int unsigned width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [width-1:0] limit,
    output logic [width-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             err,
    output logic [7:0]       periods
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [width-1:0] count_d;
    logic [width-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic [7:0]       periods_d;
    logic             done_d, err_d;
    logic             busy_d, paused_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count   <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            periods <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            paused  <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            periods <= periods_d;
            done    <= done_d;
            err     <= err_d;
            busy    <= busy_d;
            paused  <= paused_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count;
        limit_d   = limit_q;
        mode_d    = mode_q;
        periods_d = periods;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start && (limit != '0)) begin
            limit_d   = limit;
            mode_d    = mode;
            count_d   = '0;
            periods_d = '0;
            state_d   = RUN;
        end else begin
            // A rejected start only flags err; the run keeps advancing.
            if (start) begin
                err_d = 1'b1;
            end
            if (state_q != IDLE) begin
                if (pause) begin
                    state_d = HOLD;
                end else if (count == limit_q) begin
                    count_d   = '0;
                    done_d    = 1'b1;
                    periods_d = periods + 8'd1;
                    state_d   = mode_q ? RUN : IDLE;
                end else begin
                    count_d = count + {{(width-1){1'b0}}, 1'b1};
                    state_d = RUN;
                end
            end
        end

        // Status flags are registered from the next state so they line up
        // with count on the same cycle.
        busy_d   = (state_d != IDLE);
        paused_d = (state_d == HOLD);
    end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, mode;
    logic [3:0] limit;
    logic [3:0] count;
    logic       busy, paused, done, err;
    logic [7:0] periods;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] obs, exp_v;
    assign obs = {busy, paused, done, err, count, periods};

    counter_sequencer #(.width(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .limit(limit), .count(count), .busy(busy),
        .paused(paused), .done(done), .err(err), .periods(periods)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pk(input logic b, input logic p,
                                       input logic d, input logic e,
                                       input logic [3:0] c, input logic [7:0] n);
        return {b, p, d, e, c, n};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l, input logic m);
        start = 1'b1; limit = l; mode = m;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; pause = 0; mode = 0; limit = '0;
        tick(); tick();
        rst = 1'b0;
        exp_v = pk(0, 0, 0, 0, 4'd0, 8'd0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_initial: got %h expected %h", obs, exp_v); end
        do_start(4'd9, 1'b1);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_midrun: got %h expected %h", obs, exp_v); end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_stays_idle: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_oneshot();
        do_start(4'd5, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            exp_v = pk(1, 0, 0, 0, 4'(k), 8'd0);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL oneshot_count k=%0d: got %h expected %h", k, obs, exp_v); end
        end
        tick();
        exp_v = pk(0, 0, 1, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL oneshot_done: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pk(0, 0, 0, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL oneshot_idle_after: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_autoreload();
        do_start(4'd2, 1'b1);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) tick();
            exp_v = pk(1, 0, (k > 0) && (k % 3 == 0), 0, 4'(k % 3), 8'(k / 3));
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL autoreload k=%0d: got %h expected %h", k, obs, exp_v); end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp_v = pk(0, 0, 0, 0, 4'd0, 8'd3);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL autoreload_stop: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_pause();
        do_start(4'd15, 1'b0);
        tick(); tick(); tick(); tick();
        // IDLE-ignored pause is also harmless here; count is 4 now
        pause = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            tick();
            exp_v = pk(1, 1, 0, 0, 4'd4, 8'd0);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL pause_hold edge=%0d: got %h expected %h", k, obs, exp_v); end
        end
        pause = 1'b0;
        for (int k = 8; k <= 18; k++) begin
            tick();
            exp_v = pk(1, 0, 0, 0, 4'(k - 3), 8'd0);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL pause_resume edge=%0d: got %h expected %h", k, obs, exp_v); end
        end
        tick();
        exp_v = pk(0, 0, 1, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pause_done_e19: got %h expected %h", obs, exp_v); end

        // pause on the terminal edge delays done
        do_start(4'd2, 1'b0);
        tick(); tick();
        pause = 1'b1;
        tick();
        exp_v = pk(1, 1, 0, 0, 4'd2, 8'd0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pause_terminal_hold: got %h expected %h", obs, exp_v); end
        pause = 1'b0;
        tick();
        exp_v = pk(0, 0, 1, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pause_terminal_done: got %h expected %h", obs, exp_v); end

        // pause in IDLE has no effect
        pause = 1'b1;
        tick();
        pause = 1'b0;
        exp_v = pk(0, 0, 0, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL pause_idle: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_simultaneous();
        do_start(4'd9, 1'b1);
        for (int k = 1; k <= 7; k++) tick();
        start = 1'b1; stop = 1'b1; limit = 4'd3;
        tick();
        start = 1'b0; stop = 1'b0;
        exp_v = pk(0, 0, 0, 0, 4'd0, 8'd0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL start_stop: got %h expected %h", obs, exp_v); end

        // restart on the terminal edge of an auto-reload run
        do_start(4'd2, 1'b1);
        tick(); tick();
        do_start(4'd3, 1'b0);
        exp_v = pk(1, 0, 0, 0, 4'd0, 8'd0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL restart_terminal: got %h expected %h", obs, exp_v); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_v = pk(1, 0, 0, 0, 4'(k), 8'd0);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL restart_count k=%0d: got %h expected %h", k, obs, exp_v); end
        end
        tick();
        exp_v = pk(0, 0, 1, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL restart_done: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_reject();
        do_start(4'd0, 1'b1);
        exp_v = pk(0, 0, 0, 1, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reject_idle: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pk(0, 0, 0, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reject_idle_clear: got %h expected %h", obs, exp_v); end

        do_start(4'd12, 1'b0);
        for (int k = 1; k <= 9; k++) tick();
        do_start(4'd0, 1'b1);
        exp_v = pk(1, 0, 0, 1, 4'd10, 8'd0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reject_run: got %h expected %h", obs, exp_v); end
        limit = 4'd15; mode = 1'b1;
        tick(); tick();
        exp_v = pk(1, 0, 0, 0, 4'd12, 8'd0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reject_run_cont: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pk(0, 0, 1, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reject_limit_kept: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_full_range();
        do_start(4'd15, 1'b1);
        for (int k = 1; k <= 15; k++) tick();
        exp_v = pk(1, 0, 0, 0, 4'd15, 8'd0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL full_range_top: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pk(1, 0, 1, 0, 4'd0, 8'd1);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL full_range_wrap: got %h expected %h", obs, exp_v); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_simultaneous();
        test_reject();
        test_full_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
